// File: rtl/plab5_mcore_mem_net_req_arbiter_pkg.sv
// Shared definitions for the memory-request network arbiter: grant-id width,
// requester message slicing, and TDM defaults (used when PLAB5_MCORE_ARB_TDM_EN is set).
package plab5_mcore_mem_net_req_arbiter_pkg;

    localparam int unsigned TDM_DEF_SLOT_CYCLES = 16;
    localparam int unsigned TDM_DEF_DOMAIN_MASK = 0;

    // Grant-id width; never narrower than one bit.
    function automatic int unsigned gid_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB of requester i's message inside the flattened in_msg bus.
    function automatic int unsigned msg_lsb(input int unsigned i, input int unsigned nbits);
        return i * nbits;
    endfunction

endpackage

// File: rtl/plab5_mcore_mem_net_req_arbiter_rr.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping
// from p_num_reqs-1 back to 0. Returns one-hot grant, its index and a found flag.
module plab5_mcore_rr_arbiter
    import plab5_mcore_mem_net_req_arbiter_pkg::*;
#(
    parameter int unsigned p_num_reqs = 2
) (
    input  logic [p_num_reqs-1:0]        req_i,
    input  logic [gid_w(p_num_reqs)-1:0] ptr_i,
    output logic [p_num_reqs-1:0]        gnt_o,
    output logic [gid_w(p_num_reqs)-1:0] idx_o,
    output logic                         any_o
);
    localparam int unsigned IW = gid_w(p_num_reqs);

    logic [IW-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int k = 0; k < int'(p_num_reqs); k++) begin
            j = IW'((int'(ptr_i) + k) % int'(p_num_reqs));
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/plab5_mcore_mem_net_req_arbiter.sv
// Round-robin arbiter sharing one network injection port between p_num_reqs
// request streams, with a single registered output stage. Macro PLAB5_MCORE_ARB_TDM_EN adds domain TDM slots.
module plab5_mcore_mem_net_req_arbiter
    import plab5_mcore_mem_net_req_arbiter_pkg::*;
#(
    parameter int unsigned p_num_reqs    = 2,
    parameter int unsigned p_msg_nbits   = 76,
    parameter int unsigned p_domain_mask = TDM_DEF_DOMAIN_MASK,
    parameter int unsigned p_slot_cycles = TDM_DEF_SLOT_CYCLES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             in_val,
    output logic [p_num_reqs-1:0]             in_rdy,
    input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
    output logic                              out_val,
    input  logic                              out_rdy,
    output logic [p_msg_nbits-1:0]            out_msg,
    output logic [gid_w(p_num_reqs)-1:0]      out_grant_id,
    input  logic                              sd
);
    localparam int unsigned N  = p_num_reqs;
    localparam int unsigned MW = p_msg_nbits;
    localparam int unsigned IW = gid_w(p_num_reqs);

    logic           out_val_q, out_val_d;
    logic [MW-1:0]  out_msg_q, out_msg_d;
    logic [IW-1:0]  gid_q, gid_d;
    logic           load_ok, xfer;
    logic [N-1:0]   gnt;
    logic [IW-1:0]  gidx, ptr_nxt;
    logic           gany;
    logic [MW-1:0]  msgs [N];

    // sd is a label for information-flow annotations only.
    logic unused_sd;
    assign unused_sd = sd;

    for (genvar g = 0; g < int'(N); g++) begin : g_slice
        assign msgs[g] = in_msg[msg_lsb(g, MW) +: MW];
    end

    assign load_ok = !out_val_q || out_rdy;
    assign in_rdy  = reset ? '0 : gnt;
    assign xfer    = gany && !reset;
    assign ptr_nxt = (gidx == IW'(N-1)) ? '0 : gidx + 1'b1;

`ifdef PLAB5_MCORE_ARB_TDM_EN
    localparam int unsigned CW = gid_w(p_slot_cycles);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   slot_q, slot_d;
    logic [1:0][IW-1:0]     ptr_q, ptr_d;
    logic                   dead;
    logic [1:0][N-1:0]      dreq, dgnt;
    logic [1:0][IW-1:0]     didx;
    logic [1:0]             dany;

    // Last cycle of a slot never grants, so no message straddles a slot edge.
    assign dead = (cnt_q == CW'(p_slot_cycles - 1));

    for (genvar d = 0; d < 2; d++) begin : g_dom
        for (genvar i = 0; i < int'(N); i++) begin : g_req
            assign dreq[d][i] = in_val[i] && (p_domain_mask[i] == 1'(d)) &&
                                (slot_q == 1'(d)) && load_ok && !dead;
        end
        plab5_mcore_rr_arbiter #(.p_num_reqs(N)) u_rr (
            .req_i (dreq[d]),
            .ptr_i (ptr_q[d]),
            .gnt_o (dgnt[d]),
            .idx_o (didx[d]),
            .any_o (dany[d])
        );
    end

    assign gnt  = dgnt[0] | dgnt[1];
    assign gidx = slot_q ? didx[1] : didx[0];
    assign gany = |dany;

    always_comb begin
        cnt_d  = dead ? '0 : cnt_q + 1'b1;
        slot_d = dead ? !slot_q : slot_q;
        ptr_d  = ptr_q;
        if (xfer) ptr_d[slot_q] = ptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            slot_q <= 1'b0;
            ptr_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            ptr_q  <= ptr_d;
        end
    end
`else
    logic [IW-1:0] ptr_q, ptr_d;

    logic unused_tdm;
    assign unused_tdm = ^{p_domain_mask, p_slot_cycles};

    plab5_mcore_rr_arbiter #(.p_num_reqs(N)) u_rr (
        .req_i (in_val & {N{load_ok}}),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

    assign ptr_d = xfer ? ptr_nxt : ptr_q;

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    // A new grant overwrites the register even while it drains: no bubble.
    always_comb begin
        out_val_d = out_val_q;
        out_msg_d = out_msg_q;
        gid_d     = gid_q;
        if (xfer) begin
            out_val_d = 1'b1;
            out_msg_d = msgs[gidx];
            gid_d     = gidx;
        end else if (out_rdy) begin
            out_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_val_q <= 1'b0;
            out_msg_q <= '0;
            gid_q     <= '0;
        end else begin
            out_val_q <= out_val_d;
            out_msg_q <= out_msg_d;
            gid_q     <= gid_d;
        end
    end

    assign out_val      = out_val_q;
    assign out_msg      = out_msg_q;
    assign out_grant_id = gid_q;

endmodule

// File: tb/tb_plab5_mcore_mem_net_req_arbiter.sv
// Bench: directed cycle table on a 2-requester arbiter, plus a wrap sequence and
// randomized traffic against a reference model on a 4-requester arbiter.
module tb_plab5_mcore_mem_net_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 2-requester instance
    logic         a_reset, a_out_rdy, a_out_val;
    logic [1:0]   a_in_val, a_in_rdy;
    logic [151:0] a_in_msg;
    logic [75:0]  a_out_msg;
    logic [0:0]   a_gid;

    plab5_mcore_mem_net_req_arbiter #(.p_num_reqs(2), .p_msg_nbits(76)) dut_a (
        .clk(clk), .reset(a_reset), .in_val(a_in_val), .in_rdy(a_in_rdy),
        .in_msg(a_in_msg), .out_val(a_out_val), .out_rdy(a_out_rdy),
        .out_msg(a_out_msg), .out_grant_id(a_gid), .sd(1'b0)
    );

    // 4-requester instance
    logic        b_reset, b_out_rdy, b_out_val;
    logic [3:0]  b_in_val, b_in_rdy;
    logic [63:0] b_in_msg;
    logic [15:0] b_out_msg;
    logic [1:0]  b_gid;

    plab5_mcore_mem_net_req_arbiter #(.p_num_reqs(4), .p_msg_nbits(16)) dut_b (
        .clk(clk), .reset(b_reset), .in_val(b_in_val), .in_rdy(b_in_rdy),
        .in_msg(b_in_msg), .out_val(b_out_val), .out_rdy(b_out_rdy),
        .out_msg(b_out_msg), .out_grant_id(b_gid), .sd(1'b1)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One row per cycle: inputs applied, then outputs expected before the edge.
    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [75:0] m0, m1;
        logic        ordy;
        logic [1:0]  e_rdy;
        logic        e_val;
        logic [75:0] e_msg;
        logic        e_id;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rst, input logic [1:0] v, input logic [75:0] m0, m1,
                       input logic ordy, input logic [1:0] erdy, input logic evl,
                       input logic [75:0] emsg, input logic eid);
        vec_t r;
        r = '{rst, v, m0, m1, ordy, erdy, evl, emsg, eid};
        vecs.push_back(r);
    endtask

    // Reference model for the 4-requester instance: a one-entry holding slot
    // plus a priority pointer; the winner is the valid requester nearest the
    // pointer going upward modulo 4.
    bit          m_full;
    logic [15:0] m_msg;
    int          m_id, m_ptr;

    function automatic int pick(input logic [3:0] v, input int ptr);
        int best = -1;
        int bestd = 4;
        for (int i = 0; i < 4; i++)
            if (v[i] && ((i - ptr + 4) % 4) < bestd) begin
                best  = i;
                bestd = (i - ptr + 4) % 4;
            end
        return best;
    endfunction

    task automatic step_b(input logic rst, input logic [3:0] v, input logic [63:0] msgs,
                          input logic ordy);
        int g;
        logic [3:0] erdy;
        @(negedge clk);
        b_reset = rst; b_in_val = v; b_in_msg = msgs; b_out_rdy = ordy;
        #1;
        g = (rst || !(!m_full || ordy)) ? -1 : pick(v, m_ptr);
        erdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("B in_rdy", b_in_rdy, erdy);
        chk("B out_val", b_out_val, m_full);
        chk("B out_msg", b_out_msg, m_msg);
        chk("B out_grant_id", b_gid, m_id[1:0]);
        if (rst) begin
            m_full = 0; m_msg = '0; m_id = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_full = 1; m_msg = msgs[g*16 +: 16]; m_id = g; m_ptr = (g + 1) % 4;
        end else if (ordy) begin
            m_full = 0;
        end
    endtask

    initial begin
        a_reset = 1; a_in_val = '0; a_in_msg = '0; a_out_rdy = 1;
        b_reset = 1; b_in_val = '0; b_in_msg = '0; b_out_rdy = 1;
        m_full = 0; m_msg = '0; m_id = 0; m_ptr = 0;

        //   rst v      m0     m1     ordy erdy   val  msg    id
        row(0, 2'b01, 'hA5,  'h0,   1, 2'b01, 0, 'h0,  0);  // single requester
        row(0, 2'b00, 'h0,   'h0,   1, 2'b00, 1, 'hA5, 0);
        row(0, 2'b11, 'h10,  'h11,  1, 2'b10, 0, 'hA5, 0);  // ptr=1 after req0
        row(0, 2'b11, 'h20,  'h21,  1, 2'b01, 1, 'h11, 1);  // alternation
        row(0, 2'b11, 'h30,  'h31,  1, 2'b10, 1, 'h20, 0);
        row(0, 2'b11, 'h30,  'h31,  0, 2'b00, 1, 'h31, 1);  // backpressure x5
        row(0, 2'b11, 'h32,  'h33,  0, 2'b00, 1, 'h31, 1);
        row(0, 2'b11, 'h34,  'h35,  0, 2'b00, 1, 'h31, 1);
        row(0, 2'b11, 'h36,  'h37,  0, 2'b00, 1, 'h31, 1);
        row(0, 2'b11, 'h38,  'h39,  0, 2'b00, 1, 'h31, 1);
        row(0, 2'b11, 'h40,  'h41,  1, 2'b01, 1, 'h31, 1);  // drain + load
        row(0, 2'b10, 'h50,  'h51,  1, 2'b10, 1, 'h40, 0);
        row(0, 2'b00, 'h0,   'h0,   0, 2'b00, 1, 'h51, 1);
        row(0, 2'b00, 'h0,   'h0,   1, 2'b00, 1, 'h51, 1);
        row(0, 2'b00, 'h0,   'h0,   1, 2'b00, 0, 'h51, 1);  // msg holds after drain
        row(0, 2'b10, 'h60,  'h61,  1, 2'b10, 0, 'h51, 1);
        row(1, 2'b11, 'h62,  'h63,  0, 2'b00, 1, 'h61, 1);  // reset while full
        row(0, 2'b11, 'h70,  'h71,  1, 2'b01, 0, 'h0,  0);  // ptr back to 0
        row(0, 2'b00, 'h0,   'h0,   1, 2'b00, 1, 'h70, 0);

        repeat (2) @(posedge clk);

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            a_reset = vecs[n].rst; a_in_val = vecs[n].v;
            a_in_msg = {vecs[n].m1, vecs[n].m0}; a_out_rdy = vecs[n].ordy;
            #1;
            chk($sformatf("A[%0d] in_rdy", n), a_in_rdy, vecs[n].e_rdy);
            chk($sformatf("A[%0d] out_val", n), a_out_val, vecs[n].e_val);
            chk($sformatf("A[%0d] out_msg", n), a_out_msg, vecs[n].e_msg);
            chk($sformatf("A[%0d] out_grant_id", n), a_gid, vecs[n].e_id);
        end

        // 4 requesters: steer pointer to 3, then only 0..2 valid -> wrap to 0.
        step_b(1, 4'b0000, 64'h0, 1);
        step_b(0, 4'b0100, 64'h0000_2222_0000_0000, 1);
        step_b(0, 4'b0111, 64'h0000_3333_2222_1111, 1);
        chk("B wrap grant", b_in_rdy, 4'b0001);
        step_b(0, 4'b0111, 64'h0000_6666_5555_4444, 1);
        chk("B ptr after wrap", b_in_rdy, 4'b0010);

        for (int n = 0; n < 600; n++)
            step_b($urandom_range(0, 49) == 0, 4'($urandom),
                   {$urandom, $urandom}, $urandom_range(0, 3) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
